// File: rtl/i2c_pkg.sv
// Shared I2C definitions: widths and the target FSM state encoding.
package i2c_pkg;

  localparam int I2C_ADDR_W = 7;
  localparam int I2C_BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    RX_DATA,
    RX_ACK,
    TX_DATA,
    TX_ACK,
    IGNORE
  } i2c_slv_state_t;

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchronizer with edge, START and STOP detection.
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_d;
  logic                   sda_d;
  logic                   scl;

  // Idle bus level is high, so reset to 1 to avoid a false edge after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
      scl_d    <= scl_sync[SYNC_STAGES-1];
      sda_d    <= sda_sync[SYNC_STAGES-1];
    end
  end

  assign scl      = scl_sync[SYNC_STAGES-1];
  assign sda      = sda_sync[SYNC_STAGES-1];
  assign scl_rise = scl & ~scl_d;
  assign scl_fall = ~scl & scl_d;
  // SDA moving while SCL stays high is a bus condition, not data.
  assign start    = scl & scl_d & sda_d & ~sda;
  assign stop     = scl & scl_d & ~sda_d & sda;

endmodule

// File: rtl/i2c_slave_core.sv
// I2C target engine: address match, write receive, read transmit.
// Optional clock stretching on TX underrun when I2C_SLAVE_CLK_STRETCH_EN is defined.
module i2c_slave_core
  import i2c_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [I2C_ADDR_W-1:0] addr_device,
  input  logic                  scl_i,
  input  logic                  sda_i,
  output logic                  scl_o,
  output logic                  sda_o,
  output logic [I2C_BYTE_W-1:0] rx_data,
  output logic                  rx_valid,
  input  logic [I2C_BYTE_W-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ack,
  output logic                  addr_match,
  output logic                  rw,
  output logic                  stop_det,
  output logic                  nack_det,
  output logic                  tx_underrun,
  output logic                  busy,
  output i2c_slv_state_t        fsm_state
);

  logic sda, scl_rise, scl_fall, start, stop;

  i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .rst      (rst),
    .scl_i    (scl_i),
    .sda_i    (sda_i),
    .sda      (sda),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start),
    .stop     (stop)
  );

  i2c_slv_state_t        state, state_n;
  logic [3:0]            cnt, cnt_n;
  logic [I2C_BYTE_W-1:0] shift, shift_n, rx_data_n;
  logic                  rw_n, busy_n, sda_o_n, stretch, stretch_n;
  logic                  addr_match_n, rx_valid_n, tx_ack_n;
  logic                  stop_det_n, nack_det_n, tx_underrun_n;
  logic                  load_req;

  assign fsm_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      shift       <= '0;
      rx_data     <= '0;
      rw          <= 1'b0;
      busy        <= 1'b0;
      sda_o       <= 1'b1;
      stretch     <= 1'b0;
      addr_match  <= 1'b0;
      rx_valid    <= 1'b0;
      tx_ack      <= 1'b0;
      stop_det    <= 1'b0;
      nack_det    <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      shift       <= shift_n;
      rx_data     <= rx_data_n;
      rw          <= rw_n;
      busy        <= busy_n;
      sda_o       <= sda_o_n;
      stretch     <= stretch_n;
      addr_match  <= addr_match_n;
      rx_valid    <= rx_valid_n;
      tx_ack      <= tx_ack_n;
      stop_det    <= stop_det_n;
      nack_det    <= nack_det_n;
      tx_underrun <= tx_underrun_n;
    end
  end

  always_comb begin
    state_n = state;
    if (!enable || stop) begin
      state_n = IDLE;
    end else if (start) begin
      state_n = ADDR;
    end else begin
      case (state)
        ADDR:     if (scl_rise && cnt == 4'd7)
                    state_n = (shift[6:0] == addr_device) ? ADDR_ACK : IGNORE;
        ADDR_ACK: if (scl_fall && cnt == 4'd1) state_n = rw ? TX_DATA : RX_DATA;
        RX_DATA:  if (scl_rise && cnt == 4'd7) state_n = RX_ACK;
        RX_ACK:   if (scl_fall && cnt == 4'd1) state_n = RX_DATA;
        TX_DATA:  if (scl_fall && cnt == 4'd8) state_n = TX_ACK;
        TX_ACK:   if (scl_rise) state_n = sda ? IGNORE : TX_DATA;
        default:  state_n = state;
      endcase
    end
  end

  // Read handshake: tx_valid is a level meaning tx_data holds the next byte;
  // tx_ack pulses for one cycle in the cycle the byte enters the shifter.
  // A load happens at the SCL fall that opens bit 1 (cnt == 0 in TX_DATA),
  // or every cycle while stretching.
  assign load_req = (state == ADDR_ACK && scl_fall && cnt == 4'd1 && rw) ||
                    (state == TX_DATA && cnt == 4'd0 && (scl_fall || stretch));

  always_comb begin
    cnt_n         = cnt;
    shift_n       = shift;
    rx_data_n     = rx_data;
    rw_n          = rw;
    busy_n        = busy;
    sda_o_n       = sda_o;
    stretch_n     = stretch;
    addr_match_n  = 1'b0;
    rx_valid_n    = 1'b0;
    tx_ack_n      = 1'b0;
    stop_det_n    = 1'b0;
    nack_det_n    = 1'b0;
    tx_underrun_n = 1'b0;
    if (!enable || stop) begin
      cnt_n      = '0;
      shift_n    = '0;
      busy_n     = 1'b0;
      sda_o_n    = 1'b1;
      stretch_n  = 1'b0;
      stop_det_n = enable;
    end else if (start) begin
      cnt_n     = '0;
      shift_n   = '0;
      busy_n    = 1'b1;
      sda_o_n   = 1'b1;
      stretch_n = 1'b0;
    end else begin
      case (state)
        ADDR, RX_DATA: if (scl_rise) begin
          shift_n = {shift[6:0], sda};
          cnt_n   = cnt + 4'd1;
          if (cnt == 4'd7) begin
            cnt_n = '0;
            if (state == ADDR) begin
              if (shift[6:0] == addr_device) begin
                addr_match_n = 1'b1;
                rw_n         = sda;
              end
            end else begin
              rx_data_n  = {shift[6:0], sda};
              rx_valid_n = 1'b1;
            end
          end
        end
        ADDR_ACK, RX_ACK: if (scl_fall) begin
          sda_o_n = (cnt != 4'd0);
          cnt_n   = (cnt == 4'd0) ? 4'd1 : 4'd0;
        end
        TX_DATA: if (scl_fall && cnt == 4'd8) begin
          sda_o_n = 1'b1;
          cnt_n   = '0;
        end else if (scl_fall && cnt != 4'd0) begin
          shift_n = shift << 1;
          sda_o_n = shift[6];
          cnt_n   = cnt + 4'd1;
        end
        TX_ACK: if (scl_rise && sda) nack_det_n = 1'b1;
        default: ;
      endcase
      if (load_req) begin
        if (tx_valid) begin
          shift_n   = tx_data;
          sda_o_n   = tx_data[7];
          tx_ack_n  = 1'b1;
          cnt_n     = 4'd1;
          stretch_n = 1'b0;
        end else begin
`ifdef I2C_SLAVE_CLK_STRETCH_EN
          stretch_n = 1'b1;
          sda_o_n   = 1'b1;
          cnt_n     = '0;
`else
          shift_n       = '1;
          sda_o_n       = 1'b1;
          tx_underrun_n = 1'b1;
          cnt_n         = 4'd1;
`endif
        end
      end
    end
  end

`ifdef I2C_SLAVE_CLK_STRETCH_EN
  // SCL stays held through the load cycle and is released one cycle after it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) scl_o <= 1'b1;
    else     scl_o <= !(stretch_n || (stretch && tx_ack_n));
  end
`else
  assign scl_o = 1'b1;
`endif

endmodule

// File: tb/tb_i2c_slave_core.sv
// Bench for i2c_slave_core: a bit-level bus master, pulse monitor and byte scoreboard.
module tb_i2c_slave_core;
  import i2c_pkg::*;

  logic           clk = 1'b0;
  logic           rst, enable;
  logic [6:0]     addr_device;
  logic           scl_m, sda_m, scl_line, sda_line;
  logic           scl_o, sda_o;
  logic [7:0]     rx_data, tx_data;
  logic           rx_valid, tx_valid, tx_ack, addr_match, rw;
  logic           stop_det, nack_det, tx_underrun, busy;
  i2c_slv_state_t fsm_state;

  i2c_slave_core dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .addr_device (addr_device),
    .scl_i       (scl_line),
    .sda_i       (sda_line),
    .scl_o       (scl_o),
    .sda_o       (sda_o),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ack      (tx_ack),
    .addr_match  (addr_match),
    .rw          (rw),
    .stop_det    (stop_det),
    .nack_det    (nack_det),
    .tx_underrun (tx_underrun),
    .busy        (busy),
    .fsm_state   (fsm_state)
  );

  // Clock / wired-AND bus
  always #5 clk = ~clk;
  assign scl_line = scl_m & scl_o;
  assign sda_line = sda_m & sda_o;

  int total = 0, bad = 0;
  int n_match = 0, n_txack = 0, n_nack = 0, n_stop = 0, n_under = 0, n_viol = 0;
  int base_match, base_txack, base_nack, base_stop, base_under;
  logic       last_rw = 1'b0;
  logic       sda_o_prev = 1'b1;
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] wdata[4];
  logic [7:0] rdata[4];

  // Monitor: collect pulses and received bytes; flag sda_o moving while SCL is high
  always @(negedge clk) begin
    if (rx_valid)    rx_q.push_back(rx_data);
    if (addr_match)  begin n_match++; last_rw = rw; end
    if (tx_ack)      n_txack++;
    if (nack_det)    n_nack++;
    if (stop_det)    n_stop++;
    if (tx_underrun) n_under++;
    if (scl_line && sda_o !== sda_o_prev) n_viol++;
    sda_o_prev = sda_o;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    base_match = n_match; base_txack = n_txack; base_nack = n_nack;
    base_stop  = n_stop;  base_under = n_under;
  endtask

  // Driver tasks (bus master)
  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_scl_high();
    int t = 0;
    while (scl_line !== 1'b1 && t < 400) begin wait_cyc(1); t++; end
    check("scl_high_timeout", 32'(scl_line), 32'd1);
  endtask

  task automatic bus_start();
    sda_m = 1'b0; wait_cyc(8); scl_m = 1'b0;
  endtask

  task automatic bus_rstart();
    wait_cyc(4); sda_m = 1'b1; wait_cyc(4); scl_m = 1'b1; wait_scl_high();
    wait_cyc(8); sda_m = 1'b0; wait_cyc(8); scl_m = 1'b0;
  endtask

  task automatic bus_stop();
    wait_cyc(4); sda_m = 1'b0; wait_cyc(4); scl_m = 1'b1; wait_scl_high();
    wait_cyc(8); sda_m = 1'b1; wait_cyc(8);
  endtask

  task automatic bus_bit(input logic b, output logic seen);
    wait_cyc(4); sda_m = b; wait_cyc(4);
    scl_m = 1'b1; wait_scl_high();
    wait_cyc(4); seen = sda_line; wait_cyc(4);
    scl_m = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bus_bit(d[i], s);
    bus_bit(1'b1, ack);
  endtask

  task automatic read_bits(output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin bus_bit(1'b1, s); d[i] = s; end
  endtask

  task automatic write_txn(input bit rep, input logic [7:0] ab, input int n, input bit do_stop);
    logic ack;
    bit   match;
    snap();
    if (rep) bus_rstart(); else bus_start();
    check("busy_start", 32'(busy), 32'd1);
    match = (ab[7:1] == addr_device);
    write_byte(ab, ack);
    check("addr_ack", 32'(ack), 32'(!match));
    if (match) check("rw_write", 32'(rw), 32'd0);
    else       check("ignore_state", 32'(fsm_state), 32'(IGNORE));
    for (int i = 0; i < n; i++) begin
      write_byte(wdata[i], ack);
      check("data_ack", 32'(ack), 32'(!match));
      if (match) exp_q.push_back(wdata[i]);
    end
    if (do_stop) begin
      bus_stop();
      check("busy_stop", 32'(busy), 32'd0);
      check("idle_stop", 32'(fsm_state), 32'(IDLE));
    end
    check("match_cnt", 32'(n_match - base_match), 32'(match));
    check("stop_cnt", 32'(n_stop - base_stop), 32'(do_stop));
    check("rx_cnt", 32'(rx_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && rx_q.size() > 0)
      check("rx_data", 32'(rx_q.pop_front()), 32'(exp_q.pop_front()));
    exp_q.delete();
    rx_q.delete();
  endtask

  task automatic read_txn(input bit rep, input logic [7:0] ab, input int n);
    logic       ack, s;
    logic [7:0] got;
    bit         match;
    snap();
    tx_data = rdata[0]; tx_valid = 1'b1;
    if (rep) bus_rstart(); else bus_start();
    match = (ab[7:1] == addr_device);
    write_byte(ab, ack);
    check("raddr_ack", 32'(ack), 32'(!match));
    if (match) begin
      check("rw_read", 32'(rw), 32'd1);
      for (int i = 0; i < n; i++) begin
        read_bits(got);
        check("tx_byte", 32'(got), 32'(rdata[i]));
        if (i + 1 < n) tx_data = rdata[i+1];
        bus_bit(i == n - 1, s);
      end
    end
    bus_stop();
    tx_valid = 1'b0;
    check("rmatch_cnt", 32'(n_match - base_match), 32'(match));
    if (match) check("last_rw", 32'(last_rw), 32'd1);
    check("txack_cnt", 32'(n_txack - base_txack), match ? 32'(n) : 32'd0);
    check("nack_cnt", 32'(n_nack - base_nack), 32'(match));
    check("under_cnt", 32'(n_under - base_under), 32'd0);
    check("rstop_cnt", 32'(n_stop - base_stop), 32'd1);
    check("rbusy_stop", 32'(busy), 32'd0);
  endtask

  task automatic abort_rx(input bit use_rst);
    logic ack, s;
    snap();
    addr_device = 7'h3A;
    bus_start();
    write_byte(8'h74, ack);
    check("abort_addr_ack", 32'(ack), 32'd0);
    for (int i = 0; i < 3; i++) bus_bit(i[0], s);
    wait_cyc(4); sda_m = 1'b1; wait_cyc(4); scl_m = 1'b1; wait_cyc(4);
    if (use_rst) rst = 1'b1; else enable = 1'b0;
    wait_cyc(1);
    check("abort_sda", 32'(sda_o), 32'd1);
    check("abort_scl", 32'(scl_o), 32'd1);
    check("abort_state", 32'(fsm_state), 32'(IDLE));
    check("abort_busy", 32'(busy), 32'd0);
    wait_cyc(4); scl_m = 1'b0;
    bus_stop();
    rst = 1'b0; enable = 1'b1;
    wait_cyc(8);
    check("abort_no_rx", 32'(rx_q.size()), 32'd0);
    check("abort_no_stop", 32'(n_stop - base_stop), 32'd0);
    rx_q.delete();
  endtask

  initial begin
    logic       ack, s, match;
    logic [7:0] got, exp_byte;
    logic [6:0] a7;
    int         t, n;

    // Reset block
    rst = 1'b1; enable = 1'b1; addr_device = 7'h3A;
    scl_m = 1'b1; sda_m = 1'b1; tx_data = '0; tx_valid = 1'b0;
    wait_cyc(5);
    check("rst_sda_o", 32'(sda_o), 32'd1);
    check("rst_scl_o", 32'(scl_o), 32'd1);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    check("rst_rw", 32'(rw), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_pulses", 32'({rx_valid, tx_ack, addr_match, stop_det, nack_det, tx_underrun}), 32'd0);
    check("rst_state", 32'(fsm_state), 32'(IDLE));
    rst = 1'b0;
    wait_cyc(10);

    // Write to matching address
    wdata[0] = 8'hA5; wdata[1] = 8'h5A;
    write_txn(1'b0, 8'h74, 2, 1'b1);

    // Address mismatch, then a matched transfer still works
    write_txn(1'b0, 8'h76, 0, 1'b1);
    wdata[0] = 8'h3C;
    write_txn(1'b0, 8'h74, 1, 1'b1);

    // Read with ACK then NACK
    rdata[0] = 8'hC3; rdata[1] = 8'h3C;
    read_txn(1'b0, 8'h75, 2);

    // Repeated START from write into read
    wdata[0] = 8'h11;
    write_txn(1'b0, 8'h74, 1, 1'b0);
    rdata[0] = 8'h96;
    read_txn(1'b1, 8'h75, 1);

    // Read with tx_valid low at the load point
    snap();
    tx_valid = 1'b0; tx_data = 8'hC3; got = '0;
    bus_start();
    fork
      begin
        write_byte(8'h75, ack);
        read_bits(got);
        bus_bit(1'b1, s);
      end
      begin
`ifdef I2C_SLAVE_CLK_STRETCH_EN
        t = 0;
        while (scl_o !== 1'b0 && t < 600) begin wait_cyc(1); t++; end
        check("stretch_hold", 32'(scl_o), 32'd0);
        wait_cyc(20);
        check("stretch_still", 32'(scl_o), 32'd0);
        check("stretch_no_early_ack", 32'(n_txack - base_txack), 32'd0);
        tx_valid = 1'b1;
        t = 0;
        while (tx_ack !== 1'b1 && t < 50) begin wait_cyc(1); t++; end
        check("stretch_tx_ack", 32'(tx_ack), 32'd1);
        check("stretch_scl_at_load", 32'(scl_o), 32'd0);
        wait_cyc(1);
        check("stretch_scl_release", 32'(scl_o), 32'd1);
`else
        wait_cyc(1);
`endif
      end
    join
    bus_stop();
    tx_valid = 1'b0;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
    exp_byte = 8'hC3;
    check("uf_txack_cnt", 32'(n_txack - base_txack), 32'd1);
    check("uf_under_cnt", 32'(n_under - base_under), 32'd0);
`else
    exp_byte = 8'hFF;
    check("uf_txack_cnt", 32'(n_txack - base_txack), 32'd0);
    check("uf_under_cnt", 32'(n_under - base_under), 32'd1);
    check("uf_scl_o", 32'(scl_o), 32'd1);
`endif
    check("uf_addr_ack", 32'(ack), 32'd0);
    check("uf_byte", 32'(got), 32'(exp_byte));
    check("uf_nack_cnt", 32'(n_nack - base_nack), 32'd1);

    // Abort mid RX byte
    abort_rx(1'b1);
    abort_rx(1'b0);
    wdata[0] = 8'h42;
    write_txn(1'b0, 8'h74, 1, 1'b1);

    // Randomized transfers against the byte-level reference model
    for (int k = 0; k < 8; k++) begin
      addr_device = 7'($urandom_range(0, 127));
      match = ($urandom_range(0, 3) != 0);
      a7 = match ? addr_device : (addr_device ^ 7'($urandom_range(1, 127)));
      n = $urandom_range(1, 4);
      for (int i = 0; i < 4; i++) begin
        wdata[i] = 8'($urandom);
        rdata[i] = 8'($urandom);
      end
      if ($urandom_range(0, 1) == 1) write_txn(1'b0, {a7, 1'b0}, n, 1'b1);
      else                           read_txn(1'b0, {a7, 1'b1}, n);
    end

    check("sda_o_stable_scl_high", 32'(n_viol), 32'd0);

    // Final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2c_slave_core.md
# i2c_slave_core

I2C target (slave) engine: the responder at the far end of the bus from the I2C master core. It watches the open-drain SCL/SDA pads, detects START/STOP, matches a programmable 7-bit address, and ACKs it. It receives written bytes into a byte-wide valid interface and serves read bytes from a byte-wide valid/ack interface. It sits beside the master core under the I2C top, sharing the same pads through the codebase's mode select.

## Interface
- `SYNC_STAGES`, default 2: number of flops in the scl_i/sda_i synchronizer (≥2).
- `clk` in 1: system clock (PCLK domain).
- `rst` in 1: asynchronous, active-high reset.
- `enable` in 1: block active; low forces IDLE and releases the pads.
- `addr_device` in 7: own address, sampled at address compare.
- `scl_i`, `sda_i` in 1: pad inputs (bus level).
- `scl_o`, `sda_o` out 1: open-drain controls; 0 drives the line low, 1 releases it.
- `rx_data` out 8: last received write byte.
- `rx_valid` out 1: 1-cycle pulse; `rx_data` updated the same cycle.
- `tx_data` in 8: byte to return on a read.
- `tx_valid` in 1: level; `tx_data` is available.
- `tx_ack` out 1: 1-cycle pulse; `tx_data` was consumed this cycle.
- `addr_match` out 1: pulse on a matched address; `rw` valid from this cycle.
- `rw` out 1: direction of the current transfer (1 = master read).
- `stop_det`, `nack_det`, `tx_underrun` out 1: event pulses.
- `busy` out 1: high from START until STOP.

## Operation
- Synchronizer feeds an edge detector, which produces `scl_rise`, `scl_fall`, `start` and `stop`.
  - `start`: SDA falls while SCL is high.
  - `stop`: SDA rises while SCL is high.
- States: IDLE, ADDR, ADDR_ACK, RX_DATA, RX_ACK, TX_DATA, TX_ACK, IGNORE.
- IDLE → ADDR on `start`. Bit counter is cleared and `busy` goes to 1.
- ADDR: shift `sda` MSB-first on each `scl_rise`. After 8 bits, compare [7:1] with `addr_device`.
  - Match → ADDR_ACK; pulse `addr_match`; latch `rw` = bit0.
  - Mismatch → IGNORE.
- ADDR_ACK: on the next `scl_fall`, drive `sda_o` = 0. On the following `scl_fall`, release `sda_o`. Then:
  - rw = 0 → RX_DATA.
  - rw = 1 → TX_DATA, with the byte loaded at the ACK-ending `scl_fall`.
- RX_DATA: shift 8 bits on `scl_rise`. After the 8th bit, update `rx_data` and pulse `rx_valid`, then → RX_ACK.
- RX_ACK: always ACK (drive low for bit 9), then → RX_DATA.
- TX byte load occurs at the `scl_fall` that opens bit 1:
  - `tx_valid` = 1 → load `tx_data` and pulse `tx_ack`.
  - Otherwise see Configuration.
- TX_DATA: drive `sda_o` = shift MSB after each `scl_fall`, 8 bits. Then release SDA → TX_ACK.
- TX_ACK: sample `sda` on the 9th `scl_rise`.
  - 0 → TX_DATA (next load).
  - 1 → pulse `nack_det` → IGNORE.
- IGNORE: pads released; wait for `start` or `stop`.
- Priority, checked every cycle: `!enable` > `stop` > `start` > normal transitions.
  - `stop` in any state → IDLE, pulse `stop_det`, `busy` = 0.
  - `start` (repeated) in any state → ADDR, counter cleared, `busy` stays 1.
- Reset or `!enable` mid-byte: shift state is discarded, pads are released immediately, and no pulses fire.

## Timing
- Reset values: `sda_o` = 1, `scl_o` = 1, `rx_data` = 0, `rw` = 0, `busy` = 0, all pulses 0, state IDLE.
- Pad to event: SYNC_STAGES + 1 cycles (3 at default).
- `sda_o` changes 1 cycle after the `scl_fall` event. It never changes while the synced SCL is high.
- `rx_valid` fires 1 cycle after the 8th data `scl_rise` event.
- `addr_match` fires 1 cycle after the 8th address `scl_rise` event.
- `tx_ack` fires in the same cycle as the shift-register load.
- SCL high and low phases must each be ≥ SYNC_STAGES + 2 clk cycles. Faster buses are unsupported.

## Configuration
- `I2C_SLAVE_CLK_STRETCH_EN` defined: at a TX load with `tx_valid` = 0, hold `scl_o` = 0 until `tx_valid` = 1.
  - Load and `tx_ack` occur when `tx_valid` = 1; `scl_o` is released 1 cycle later.
  - No timeout. `stop`, `start` or `!enable` aborts the stretch and releases SCL.
- Not defined: `scl_o` is tied to 1. A load with `tx_valid` = 0 sends 0xFF and pulses `tx_underrun`, with no `tx_ack`.

## Structure
- Shared package `i2c_pkg`:
  - state enum `i2c_slv_state_t`;
  - `I2C_ADDR_W` = 7;
  - `I2C_BYTE_W` = 8.
- Sub-module `i2c_bus_sync`: parameterised synchronizer plus edge/START/STOP detector, producing `scl_rise`, `scl_fall`, `start`, `stop`, and synced SDA.
- FSM, shift register and 4-bit bit counter live in `i2c_slave_core`.

## Test plan
- Write to matching address:
  - Stimulus: `addr_device` = 0x3A; master sends START, 0x74, 0xA5, 0x5A, STOP.
  - Required response: three ACK lows; `addr_match` with `rw` = 0; `rx_valid` ×2 with `rx_data` 0xA5 then 0x5A; `stop_det`; `busy` = 0.
- Address mismatch:
  - Stimulus: START, 0x76.
  - Required response: no ACK (`sda_o` stays 1), no pulses, IGNORE until STOP; next matched START works.
- Read with ACK then NACK:
  - Stimulus: START, 0x75; `tx_data` = 0xC3 then 0x3C; master ACKs byte 1, NACKs byte 2.
  - Required response: bus carries 0xC3, 0x3C; `tx_ack` ×2; `nack_det` ×1.
- Repeated START:
  - Stimulus: START, 0x74, 0x11, then repeated START, 0x75.
  - Required response: `rx_valid` 0x11, then `addr_match` with `rw` = 1; `stop_det` not pulsed.
- Read with `tx_valid` = 0:
  - Stretch build: `scl_o` = 0 until `tx_valid` is raised 20 cycles later, then 0xC3 is sent.
  - Non-stretch build: 0xFF is sent and `tx_underrun` pulses.
- Abort mid-RX byte:
  - Stimulus: assert `rst` at bit 4 of an RX byte, and separately drop `enable` there.
  - Required response: pads released within 1 cycle, state IDLE, no `rx_valid`.
